mac_scheduler: RTL and testbench
================================

MAC_SCHEDULER -- requirements
Module: mac_scheduler

Interface
REQ-001 SHALL have parameters: COUNT_WIDTH, default 32, datapath width; NUM_REQ, default 4, requester count; ID_W, default $clog2(NUM_REQ), requester ID width.
REQ-002 SHALL have ports:
- clk  in  1  single clock, all state on rising edge.
- rst_n  in  1  reset; synchronous, active-low.
- i__cfg_we  in  1  load i__cfg_constant.
- i__cfg_constant  in  COUNT_WIDTH  multiplier constant used for real ops.
- i__req_valid  in  NUM_REQ  per-requester request.
- o__req_ready  out  NUM_REQ  per-requester grant; at most one bit high.
- i__req_pkt_1 / _2 / _3  in  NUM_REQ x COUNT_WIDTH  per-requester operands.
- i__req_sel  in  NUM_REQ x 3  per-requester {sel3,sel2,sel1}.
- i__clr  in  1  request to zero the MAC register.
- i__pause  in  1  stop granting and drain.
- o__idle  out  1  paused with no op in flight.
- o__mac_constant, o__mac_pkt_1/_2/_3  out  COUNT_WIDTH  registered drive to MAC.
- o__mac_sel1/_2/_3  out  1  registered drive to MAC.
- i__mac_read, i__mac_write  in  COUNT_WIDTH  MAC outputs.
- o__rsp_valid  out  1  response strobe; no backpressure.
- o__rsp_id  out  ID_W  requester of the response.
- o__rsp_read, o__rsp_write  out  COUNT_WIDTH  MAC register value before and after the op.

Function
REQ-003 SHALL use FSM states INIT, RUN, DRAIN, PAUSED; transitions: reset->INIT; INIT->RUN after one issue cycle; RUN->DRAIN when i__pause=1; DRAIN->PAUSED when the in-flight count reaches 0; PAUSED->RUN when i__pause=0; DRAIN->RUN when i__pause=0 before empty.
REQ-004 INIT SHALL issue one clear op: sel1=1, sel3=0, pkt_2=0, giving register=0.
REQ-005 In RUN, i__clr=1 SHALL issue a clear op that cycle, with no grant; clear has priority over requesters and produces no response.
REQ-006 In RUN with i__clr=0, SHALL grant exactly one valid requester, round-robin starting at ptr; ptr <= granted index+1 mod NUM_REQ; ptr is unchanged when there is no grant.
REQ-007 A handshake SHALL be i__req_valid[k] & o__req_ready[k] at a rising edge; o__req_ready SHALL be combinational from valid, ptr, state, and i__clr.
REQ-008 On handshake, o__mac_* SHALL take {cfg constant, pkt_1..3, sel1..3} of the winner at that edge (E0).
REQ-009 When nothing is issued, o__mac_* SHALL drive a hold op so the MAC register is unchanged: constant=1, sel1=0, sel2=0, sel3=0, pkt_2=0.
REQ-010 The scheduler SHALL capture i__mac_read/i__mac_write at E0+2; o__rsp_valid/o__rsp_id/o__rsp_read/o__rsp_write SHALL be valid for exactly one cycle following that edge. Latency: 3 edges; throughput: 1 op/cycle.
REQ-011 SHALL keep a 2-stage valid/ID shift pipeline; clear and hold ops SHALL enter it as invalid.
REQ-012 The config constant SHALL update on the edge where i__cfg_we=1; an op granted the same cycle SHALL use the old value.
REQ-013 Arithmetic SHALL wrap modulo 2^COUNT_WIDTH; the block SHALL NOT perform overflow detection.
REQ-014 o__idle = (state==PAUSED).

Reset
REQ-015 On rst_n=0 at an edge: state=INIT, ptr=0, pipeline valids=0, o__rsp_valid=0, o__rsp_id=0, o__rsp_read/write=0, o__mac_* = hold op, cfg constant=1.
REQ-016 Reset mid-operation SHALL discard in-flight ops with no response; INIT then re-zeroes the MAC register.

Structure
REQ-017 A shared package SHALL hold: COUNT_WIDTH default, the state enum, the op struct {constant, pkt_1..3, sel1..3}, and the HOLD_OP/CLEAR_OP constants.
REQ-018 Round-robin selection SHALL be a sub-module rr_arbiter (req, ptr -> one-hot grant, index); the mac datapath SHALL sit outside this block.

Verification
REQ-019 Reset then idle: first response-free cycles; MAC register reads 0 after INIT; hold ops keep it 0 for 10 cycles.
REQ-020 cfg=3; req0 pkt_1=5, pkt_2=7, sel=000 (reg*3+7) twice: rsp id0 read=0 write=7, then read=7 write=28, 3 cycles after each accept.
REQ-021 All 4 requesters continuously valid: grants 0,1,2,3,0 on consecutive cycles; responses in the same order back-to-back.
REQ-022 i__clr together with req2 valid: no grant that cycle; req2 granted next; its rsp read=0.
REQ-023 i__pause with 2 ops in flight: no grants; both responses arrive; o__idle rises the cycle after the last response; deassert -> grants resume.
REQ-024 rst_n low 1 cycle while 2 ops are in flight: no responses emitted; state INIT; next op reads 0.

Source files
------------

// File: rtl/mac_scheduler_pkg.sv
// Shared types and constants for the MAC scheduler: state encoding,
// the op bundle driven to the external MAC, and the two fixed ops.
package mac_scheduler_pkg;

    localparam int COUNT_WIDTH_DEF = 32;

    typedef enum logic [1:0] {
        INIT   = 2'd0,
        RUN    = 2'd1,
        DRAIN  = 2'd2,
        PAUSED = 2'd3
    } state_t;

    // One MAC operation at the default datapath width.
    typedef struct packed {
        logic [COUNT_WIDTH_DEF-1:0] constant;
        logic [COUNT_WIDTH_DEF-1:0] pkt_1;
        logic [COUNT_WIDTH_DEF-1:0] pkt_2;
        logic [COUNT_WIDTH_DEF-1:0] pkt_3;
        logic                       sel1;
        logic                       sel2;
        logic                       sel3;
    } op_t;

    // Leaves the MAC register unchanged: reg * 1 + 0.
    localparam op_t HOLD_OP = '{
        constant: 32'd1, pkt_1: 32'd0, pkt_2: 32'd0, pkt_3: 32'd0,
        sel1: 1'b0, sel2: 1'b0, sel3: 1'b0
    };

    // Forces the MAC register to zero: pkt_1 (0) replaces reg, add pkt_2 (0).
    localparam op_t CLEAR_OP = '{
        constant: 32'd0, pkt_1: 32'd0, pkt_2: 32'd0, pkt_3: 32'd0,
        sel1: 1'b1, sel2: 1'b0, sel3: 1'b0
    };

endpackage

// File: rtl/mac_scheduler_rr_arbiter.sv
// Round-robin picker: first asserted request at or after ptr, wrapping.
// Produces a one-hot grant plus the binary index of the winner.
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [ID_W-1:0]    i_ptr,
    output logic [NUM_REQ-1:0] o_grant,
    output logic [ID_W-1:0]    o_idx,
    output logic               o_valid
);

    int w_cand;

    // Scan requesters in priority order starting at ptr; first hit wins.
    always_comb begin
        o_grant = '0;
        o_idx   = '0;
        o_valid = 1'b0;
        w_cand  = 0;
        for (int off = 0; off < NUM_REQ; off++) begin
            w_cand = (int'(i_ptr) + off) % NUM_REQ;
            if (!o_valid && i_req[w_cand]) begin
                o_valid         = 1'b1;
                o_grant[w_cand] = 1'b1;
                o_idx           = ID_W'(w_cand);
            end
        end
    end

endmodule

// File: rtl/mac_scheduler.sv
// Arbitrates NUM_REQ requesters onto one external MAC, one op per cycle.
// Handshake: a request transfers on a rising edge where i__req_valid[k] and
// o__req_ready[k] are both high; o__req_ready is combinational, at most one
// bit set, and never depends on the requester waiting for ready first.
// Ops are driven registered to the MAC; the MAC's read/write outputs for an
// op issued at edge E0 are captured at E0+2 and presented as a one-cycle
// response strobe with the requester ID (no backpressure on responses).
module mac_scheduler
    import mac_scheduler_pkg::*;
#(
    parameter int COUNT_WIDTH = COUNT_WIDTH_DEF,
    parameter int NUM_REQ     = 4,
    parameter int ID_W        = $clog2(NUM_REQ)
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic                                  i__cfg_we,
    input  logic [COUNT_WIDTH-1:0]                i__cfg_constant,
    input  logic [NUM_REQ-1:0]                    i__req_valid,
    output logic [NUM_REQ-1:0]                    o__req_ready,
    input  logic [NUM_REQ-1:0][COUNT_WIDTH-1:0]   i__req_pkt_1,
    input  logic [NUM_REQ-1:0][COUNT_WIDTH-1:0]   i__req_pkt_2,
    input  logic [NUM_REQ-1:0][COUNT_WIDTH-1:0]   i__req_pkt_3,
    input  logic [NUM_REQ-1:0][2:0]               i__req_sel,
    input  logic                                  i__clr,
    input  logic                                  i__pause,
    output logic                                  o__idle,
    output logic [COUNT_WIDTH-1:0]                o__mac_constant,
    output logic [COUNT_WIDTH-1:0]                o__mac_pkt_1,
    output logic [COUNT_WIDTH-1:0]                o__mac_pkt_2,
    output logic [COUNT_WIDTH-1:0]                o__mac_pkt_3,
    output logic                                  o__mac_sel1,
    output logic                                  o__mac_sel2,
    output logic                                  o__mac_sel3,
    input  logic [COUNT_WIDTH-1:0]                i__mac_read,
    input  logic [COUNT_WIDTH-1:0]                i__mac_write,
    output logic                                  o__rsp_valid,
    output logic [ID_W-1:0]                       o__rsp_id,
    output logic [COUNT_WIDTH-1:0]                o__rsp_read,
    output logic [COUNT_WIDTH-1:0]                o__rsp_write,
    output state_t                                o__dbg_state
);

    // Op bundle at this instance's datapath width.
    typedef struct packed {
        logic [COUNT_WIDTH-1:0] constant;
        logic [COUNT_WIDTH-1:0] pkt_1;
        logic [COUNT_WIDTH-1:0] pkt_2;
        logic [COUNT_WIDTH-1:0] pkt_3;
        logic                   sel1;
        logic                   sel2;
        logic                   sel3;
    } mac_op_t;

    function automatic mac_op_t to_local(input op_t op);
        mac_op_t r;
        r.constant = COUNT_WIDTH'(op.constant);
        r.pkt_1    = COUNT_WIDTH'(op.pkt_1);
        r.pkt_2    = COUNT_WIDTH'(op.pkt_2);
        r.pkt_3    = COUNT_WIDTH'(op.pkt_3);
        r.sel1     = op.sel1;
        r.sel2     = op.sel2;
        r.sel3     = op.sel3;
        return r;
    endfunction

    state_t                 r_state;
    logic [ID_W-1:0]        r_ptr;
    logic [COUNT_WIDTH-1:0] r_cfg;
    mac_op_t                r_mac;
    logic                   r_v1;
    logic                   r_v2;
    logic [ID_W-1:0]        r_id1;
    logic [ID_W-1:0]        r_id2;
    logic                   r_rsp_valid;
    logic [ID_W-1:0]        r_rsp_id;
    logic [COUNT_WIDTH-1:0] r_rsp_read;
    logic [COUNT_WIDTH-1:0] r_rsp_write;

    logic [NUM_REQ-1:0]     w_grant;
    logic [ID_W-1:0]        w_idx;
    logic                   w_arb_valid;
    logic                   w_grant_en;
    logic                   w_take;
    logic [1:0]             w_inflight;
    mac_op_t                w_hold_op;
    mac_op_t                w_clear_op;
    mac_op_t                w_win_op;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_arb (
        .i_req   (i__req_valid),
        .i_ptr   (r_ptr),
        .o_grant (w_grant),
        .o_idx   (w_idx),
        .o_valid (w_arb_valid)
    );

    // Grants only in RUN; a clear or a pause request suppresses them.
    assign w_grant_en   = (r_state == RUN) && !i__clr && !i__pause;
    assign o__req_ready = w_grant_en ? w_grant : '0;
    assign w_take       = w_grant_en && w_arb_valid;
    assign w_inflight   = {1'b0, r_v1} + {1'b0, r_v2};
    assign w_hold_op    = to_local(HOLD_OP);
    assign w_clear_op   = to_local(CLEAR_OP);

    // Assemble the winner's op; constant is the value held before this edge.
    always_comb begin
        w_win_op          = w_hold_op;
        w_win_op.constant = r_cfg;
        w_win_op.pkt_1    = i__req_pkt_1[w_idx];
        w_win_op.pkt_2    = i__req_pkt_2[w_idx];
        w_win_op.pkt_3    = i__req_pkt_3[w_idx];
        w_win_op.sel1     = i__req_sel[w_idx][0];
        w_win_op.sel2     = i__req_sel[w_idx][1];
        w_win_op.sel3     = i__req_sel[w_idx][2];
    end

    // Control FSM with registered MAC drive, response pipeline and config.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= INIT;
            r_ptr       <= '0;
            r_cfg       <= COUNT_WIDTH'(1);
            r_mac       <= w_hold_op;
            r_v1        <= 1'b0;
            r_v2        <= 1'b0;
            r_id1       <= '0;
            r_id2       <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_id    <= '0;
            r_rsp_read  <= '0;
            r_rsp_write <= '0;
        end else begin
            if (i__cfg_we) begin
                r_cfg <= i__cfg_constant;
            end

            // Stage 2 and response capture: MAC outputs line up at E0+2.
            r_v2        <= r_v1;
            r_id2       <= r_id1;
            r_rsp_valid <= r_v2;
            if (r_v2) begin
                r_rsp_id    <= r_id2;
                r_rsp_read  <= i__mac_read;
                r_rsp_write <= i__mac_write;
            end

            // Default issue is a hold op that enters the pipe as invalid.
            r_mac <= w_hold_op;
            r_v1  <= 1'b0;

            case (r_state)
                INIT: begin
                    r_mac   <= w_clear_op;
                    r_state <= RUN;
                end
                RUN: begin
                    if (i__pause) begin
                        r_state <= DRAIN;
                    end else if (i__clr) begin
                        r_mac <= w_clear_op;
                    end else if (w_take) begin
                        r_mac <= w_win_op;
                        r_v1  <= 1'b1;
                        r_id1 <= w_idx;
                        if (w_idx == ID_W'(NUM_REQ - 1)) begin
                            r_ptr <= '0;
                        end else begin
                            r_ptr <= w_idx + ID_W'(1);
                        end
                    end
                end
                DRAIN: begin
                    if (!i__pause) begin
                        r_state <= RUN;
                    end else if (w_inflight == 2'd0) begin
                        r_state <= PAUSED;
                    end
                end
                PAUSED: begin
                    if (!i__pause) begin
                        r_state <= RUN;
                    end
                end
                default: r_state <= INIT;
            endcase
        end
    end

    assign o__idle         = (r_state == PAUSED);
    assign o__dbg_state    = r_state;
    assign o__mac_constant = r_mac.constant;
    assign o__mac_pkt_1    = r_mac.pkt_1;
    assign o__mac_pkt_2    = r_mac.pkt_2;
    assign o__mac_pkt_3    = r_mac.pkt_3;
    assign o__mac_sel1     = r_mac.sel1;
    assign o__mac_sel2     = r_mac.sel2;
    assign o__mac_sel3     = r_mac.sel3;
    assign o__rsp_valid    = r_rsp_valid;
    assign o__rsp_id       = r_rsp_id;
    assign o__rsp_read     = r_rsp_read;
    assign o__rsp_write    = r_rsp_write;

endmodule

// File: tb/tb_mac_scheduler.sv
// Directed bench for mac_scheduler with a behavioural MAC attached.
module tb_mac_scheduler;
  import mac_scheduler_pkg::*;

  localparam int CW = 32;
  localparam int NR = 4;
  localparam int IW = 2;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  logic                    cfg_we;
  logic [CW-1:0]           cfg_constant;
  logic [NR-1:0]           req_valid;
  logic [NR-1:0]           req_ready;
  logic [NR-1:0][CW-1:0]   req_pkt_1, req_pkt_2, req_pkt_3;
  logic [NR-1:0][2:0]      req_sel;
  logic                    clr, pause, idle;
  logic [CW-1:0]           mac_constant, mac_pkt_1, mac_pkt_2, mac_pkt_3;
  logic                    mac_sel1, mac_sel2, mac_sel3;
  logic [CW-1:0]           mac_read, mac_write;
  logic                    rsp_valid;
  logic [IW-1:0]           rsp_id;
  logic [CW-1:0]           rsp_read, rsp_write;
  state_t                  dbg_state;

  mac_scheduler dut (
    .clk(clk), .rst_n(rst_n),
    .i__cfg_we(cfg_we), .i__cfg_constant(cfg_constant),
    .i__req_valid(req_valid), .o__req_ready(req_ready),
    .i__req_pkt_1(req_pkt_1), .i__req_pkt_2(req_pkt_2), .i__req_pkt_3(req_pkt_3),
    .i__req_sel(req_sel), .i__clr(clr), .i__pause(pause), .o__idle(idle),
    .o__mac_constant(mac_constant), .o__mac_pkt_1(mac_pkt_1),
    .o__mac_pkt_2(mac_pkt_2), .o__mac_pkt_3(mac_pkt_3),
    .o__mac_sel1(mac_sel1), .o__mac_sel2(mac_sel2), .o__mac_sel3(mac_sel3),
    .i__mac_read(mac_read), .i__mac_write(mac_write),
    .o__rsp_valid(rsp_valid), .o__rsp_id(rsp_id),
    .o__rsp_read(rsp_read), .o__rsp_write(rsp_write),
    .o__dbg_state(dbg_state)
  );

  // behavioural MAC: reg <= (sel1?pkt_1:reg) * (sel2?pkt_3:constant) + (sel3?pkt_3:pkt_2)
  logic [CW-1:0] mac_reg = 32'hDEAD_BEEF;
  logic [CW-1:0] m_a, m_b, m_c, m_next;
  always_comb begin
    m_a = mac_sel1 ? mac_pkt_1 : mac_reg;
    m_b = mac_sel2 ? mac_pkt_3 : mac_constant;
    m_c = mac_sel3 ? mac_pkt_3 : mac_pkt_2;
    m_next = m_a * m_b + m_c;
  end
  initial begin
    mac_read = '0;
    mac_write = '0;
  end
  always @(posedge clk) begin
    mac_read  <= mac_reg;
    mac_write <= m_next;
    mac_reg   <= m_next;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // scoreboard: observed responses and expected queues
  logic [IW-1:0] got_id_q[$];
  logic [CW-1:0] got_rd_q[$];
  logic [CW-1:0] got_wr_q[$];
  int            got_cyc_q[$];
  logic [IW-1:0] exp_id_q[$];
  logic [CW-1:0] exp_q[$];
  logic [CW-1:0] exp_wr_q[$];

  always @(negedge clk) begin
    if (rsp_valid === 1'b1) begin
      got_id_q.push_back(rsp_id);
      got_rd_q.push_back(rsp_read);
      got_wr_q.push_back(rsp_write);
      got_cyc_q.push_back(cyc);
    end
  end

  int total = 0;
  int bad = 0;

  // driver tasks
  task automatic clear_inputs();
    cfg_we = 1'b0; cfg_constant = '0; req_valid = '0; clr = 1'b0; pause = 1'b0;
    req_pkt_1 = '0; req_pkt_2 = '0; req_pkt_3 = '0; req_sel = '0;
  endtask

  task automatic flush_q();
    got_id_q.delete(); got_rd_q.delete(); got_wr_q.delete(); got_cyc_q.delete();
    exp_id_q.delete(); exp_q.delete(); exp_wr_q.delete();
  endtask

  task automatic settle();
    repeat (6) @(negedge clk);
    flush_q();
  endtask

  task automatic do_reset();
    @(negedge clk);
    clear_inputs();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    flush_q();
  endtask

  task automatic wait_rsp(input int n);
    for (int i = 0; i < 20 && got_id_q.size() < n; i++) @(negedge clk);
    @(negedge clk);
  endtask

  // compare got_* against exp_* element by element
  task automatic test_check_rsps(input string tag);
    total++;
    if (got_id_q.size() != exp_id_q.size()) begin
      bad++;
      $display("FAIL %s_count got=%0d want=%0d", tag, got_id_q.size(), exp_id_q.size());
    end else begin
      for (int i = 0; i < exp_id_q.size(); i++) begin
        total++;
        if (got_id_q[i] !== exp_id_q[i] || got_rd_q[i] !== exp_q[i] || got_wr_q[i] !== exp_wr_q[i]) begin
          bad++;
          $display("FAIL %s_rsp%0d got id=%0d rd=%0d wr=%0d want id=%0d rd=%0d wr=%0d", tag, i,
                   got_id_q[i], got_rd_q[i], got_wr_q[i], exp_id_q[i], exp_q[i], exp_wr_q[i]);
        end
      end
    end
  endtask

  task automatic test_reset();
    clear_inputs();
    rst_n = 1'b0;
    req_valid = '1;
    repeat (3) @(negedge clk);
    total++; if (dbg_state !== INIT) begin bad++; $display("FAIL rst_state got=%0d want=%0d", dbg_state, INIT); end
    total++; if (req_ready !== 4'b0000) begin bad++; $display("FAIL rst_ready got=%b want=0000", req_ready); end
    total++; if ({rsp_valid, rsp_id, rsp_read, rsp_write} !== '0) begin bad++;
      $display("FAIL rst_rsp got v=%b id=%0d rd=%0h wr=%0h want all 0", rsp_valid, rsp_id, rsp_read, rsp_write); end
    total++; if (mac_constant !== 32'd1 || {mac_sel1, mac_sel2, mac_sel3} !== 3'b000 || mac_pkt_2 !== '0) begin bad++;
      $display("FAIL rst_hold got c=%0h sel=%b p2=%0h want c=1 sel=000 p2=0", mac_constant,
               {mac_sel1, mac_sel2, mac_sel3}, mac_pkt_2); end
    total++; if (idle !== 1'b0) begin bad++; $display("FAIL rst_idle got=%b want=0", idle); end
    req_valid = '0;
    rst_n = 1'b1;
    @(negedge clk);
    total++; if (dbg_state !== RUN) begin bad++; $display("FAIL init_to_run got=%0d want=%0d", dbg_state, RUN); end
    total++; if (mac_sel1 !== 1'b1 || mac_sel3 !== 1'b0 || mac_pkt_2 !== '0) begin bad++;
      $display("FAIL init_clear_op got sel1=%b sel3=%b p2=%0h want 1 0 0", mac_sel1, mac_sel3, mac_pkt_2); end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      total++; if (mac_reg !== '0 || rsp_valid !== 1'b0 || mac_constant !== 32'd1 || mac_sel1 !== 1'b0) begin bad++;
        $display("FAIL idle_hold%0d got reg=%0h rspv=%b c=%0h sel1=%b want 0 0 1 0", i, mac_reg, rsp_valid,
                 mac_constant, mac_sel1); end
    end
  endtask

  task automatic test_mac_op();
    int acc0, acc1;
    settle();
    cfg_we = 1'b1; cfg_constant = 32'd3;
    @(negedge clk);
    cfg_we = 1'b0;
    req_pkt_1[0] = 32'd5; req_pkt_2[0] = 32'd7; req_pkt_3[0] = '0; req_sel[0] = 3'b000;
    req_valid = 4'b0001;
    #1;
    total++; if (req_ready !== 4'b0001) begin bad++; $display("FAIL mac_ready got=%b want=0001", req_ready); end
    @(negedge clk);
    acc0 = cyc;
    total++; if (mac_constant !== 32'd3 || mac_pkt_1 !== 32'd5 || mac_pkt_2 !== 32'd7 ||
                 {mac_sel1, mac_sel2, mac_sel3} !== 3'b000) begin bad++;
      $display("FAIL mac_issue got c=%0d p1=%0d p2=%0d want c=3 p1=5 p2=7", mac_constant, mac_pkt_1, mac_pkt_2); end
    @(negedge clk);
    acc1 = cyc;
    req_valid = '0;
    wait_rsp(2);
    exp_id_q = '{2'd0, 2'd0}; exp_q = '{32'd0, 32'd7}; exp_wr_q = '{32'd7, 32'd28};
    test_check_rsps("mac");
    if (got_cyc_q.size() >= 2) begin
      total++; if (got_cyc_q[0] != acc0 + 2 || got_cyc_q[1] != acc1 + 2) begin bad++;
        $display("FAIL mac_latency got=%0d,%0d want=%0d,%0d", got_cyc_q[0], got_cyc_q[1], acc0 + 2, acc1 + 2); end
    end
  endtask

  task automatic test_cfg_same_cycle();
    settle();
    cfg_we = 1'b1; cfg_constant = 32'd2;
    req_pkt_1[1] = '0; req_pkt_2[1] = '0; req_pkt_3[1] = '0; req_sel[1] = 3'b000;
    req_valid = 4'b0010;
    #1;
    total++; if (req_ready !== 4'b0010) begin bad++; $display("FAIL cfg_ready got=%b want=0010", req_ready); end
    @(negedge clk);
    cfg_we = 1'b0;
    total++; if (mac_constant !== 32'd3) begin bad++; $display("FAIL cfg_old got=%0d want=3", mac_constant); end
    @(negedge clk);
    req_valid = '0;
    total++; if (mac_constant !== 32'd2) begin bad++; $display("FAIL cfg_new got=%0d want=2", mac_constant); end
    wait_rsp(2);
    exp_id_q = '{2'd1, 2'd1}; exp_q = '{32'd28, 32'd84}; exp_wr_q = '{32'd84, 32'd168};
    test_check_rsps("cfg");
  endtask

  task automatic test_back_to_back();
    logic [NR-1:0] exp_rdy;
    do_reset();
    for (int k = 0; k < NR; k++) begin
      req_pkt_1[k] = '0; req_pkt_2[k] = 32'(10 + k); req_pkt_3[k] = '0; req_sel[k] = 3'b000;
    end
    req_valid = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      #1;
      exp_rdy = '0;
      exp_rdy[k % NR] = 1'b1;
      total++; if (req_ready !== exp_rdy) begin bad++; $display("FAIL rr_grant%0d got=%b want=%b", k, req_ready, exp_rdy); end
      @(negedge clk);
    end
    req_valid = '0;
    wait_rsp(5);
    exp_id_q = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    exp_q    = '{32'd0, 32'd10, 32'd21, 32'd33, 32'd46};
    exp_wr_q = '{32'd10, 32'd21, 32'd33, 32'd46, 32'd56};
    test_check_rsps("rr");
    if (got_cyc_q.size() == 5) begin
      total++; if (got_cyc_q[4] != got_cyc_q[0] + 4) begin bad++;
        $display("FAIL rr_b2b got span=%0d want=4", got_cyc_q[4] - got_cyc_q[0]); end
    end
  endtask

  task automatic test_clear_priority();
    settle();
    req_pkt_2[2] = 32'd9;
    req_valid = 4'b0100;
    clr = 1'b1;
    #1;
    total++; if (req_ready !== 4'b0000) begin bad++; $display("FAIL clr_no_grant got=%b want=0000", req_ready); end
    @(negedge clk);
    clr = 1'b0;
    total++; if (mac_sel1 !== 1'b1 || mac_pkt_2 !== '0 || mac_sel3 !== 1'b0) begin bad++;
      $display("FAIL clr_op got sel1=%b p2=%0h sel3=%b want 1 0 0", mac_sel1, mac_pkt_2, mac_sel3); end
    #1;
    total++; if (req_ready !== 4'b0100) begin bad++; $display("FAIL clr_next_grant got=%b want=0100", req_ready); end
    @(negedge clk);
    req_valid = '0;
    wait_rsp(1);
    exp_id_q = '{2'd2}; exp_q = '{32'd0}; exp_wr_q = '{32'd9};
    test_check_rsps("clr");
  endtask

  task automatic test_pause();
    int nrsp, last_cyc, idle_cyc;
    logic ready_seen;
    settle();
    req_pkt_2[1] = 32'd4;
    req_valid = 4'b0010;
    repeat (2) @(negedge clk);
    pause = 1'b1;
    nrsp = 0; last_cyc = -10; idle_cyc = -1; ready_seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      #1;
      if (req_ready !== 4'b0000) ready_seen = 1'b1;
      if (rsp_valid === 1'b1) begin nrsp++; last_cyc = cyc; end
      if (idle === 1'b1 && idle_cyc < 0) idle_cyc = cyc;
      @(negedge clk);
    end
    total++; if (ready_seen !== 1'b0) begin bad++; $display("FAIL pause_grant got=1 want=0"); end
    total++; if (nrsp != 2) begin bad++; $display("FAIL pause_drain got=%0d want=2", nrsp); end
    total++; if (idle_cyc != last_cyc + 1) begin bad++;
      $display("FAIL pause_idle got=%0d want=%0d", idle_cyc, last_cyc + 1); end
    total++; if (dbg_state !== PAUSED || idle !== 1'b1) begin bad++;
      $display("FAIL pause_state got=%0d idle=%b want=%0d idle=1", dbg_state, idle, PAUSED); end
    exp_id_q = '{2'd1, 2'd1}; exp_q = '{32'd9, 32'd13}; exp_wr_q = '{32'd13, 32'd17};
    test_check_rsps("pause");
    flush_q();
    pause = 1'b0;
    @(negedge clk);
    #1;
    total++; if (req_ready !== 4'b0010) begin bad++; $display("FAIL resume_grant got=%b want=0010", req_ready); end
    @(negedge clk);
    req_valid = '0;
    wait_rsp(1);
    exp_id_q = '{2'd1}; exp_q = '{32'd17}; exp_wr_q = '{32'd21};
    test_check_rsps("resume");
  endtask

  task automatic test_reset_mid();
    int nrsp;
    settle();
    req_pkt_2[0] = 32'd100;
    req_valid = 4'b0001;
    repeat (2) @(negedge clk);
    req_valid = '0;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    total++; if (dbg_state !== INIT) begin bad++; $display("FAIL rmid_state got=%0d want=%0d", dbg_state, INIT); end
    nrsp = 0;
    for (int i = 0; i < 8; i++) begin
      if (rsp_valid === 1'b1) nrsp++;
      @(negedge clk);
    end
    total++; if (nrsp != 0) begin bad++; $display("FAIL rmid_no_rsp got=%0d want=0", nrsp); end
    req_pkt_2[2] = 32'd3;
    req_valid = 4'b0100;
    @(negedge clk);
    req_valid = '0;
    wait_rsp(1);
    exp_id_q = '{2'd2}; exp_q = '{32'd0}; exp_wr_q = '{32'd3};
    test_check_rsps("rmid");
  endtask

  initial begin
    test_reset();
    test_mac_op();
    test_cfg_same_cycle();
    test_back_to_back();
    test_clear_priority();
    test_pause();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
